// File: rtl/bcd_display_timer_pkg.sv
// Shared constants for the BCD display timer: digit width, seven-segment
// codes (gfedcba, active-high) and a counter-width helper.
package bcd_display_timer_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Width of a counter holding 0..n-1; never zero so n=1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bcd_display_timer_seg7.sv
// Combinational BCD to seven-segment decoder with a blank override.
module bcd_seg7_decoder
  import bcd_display_timer_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  input  logic             blank,
  output logic [6:0]       segments
);

  // Look up the segment pattern; blank or non-BCD codes light nothing.
  always_comb begin
    segments = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    segments = SEG_0;
        4'd1:    segments = SEG_1;
        4'd2:    segments = SEG_2;
        4'd3:    segments = SEG_3;
        4'd4:    segments = SEG_4;
        4'd5:    segments = SEG_5;
        4'd6:    segments = SEG_6;
        4'd7:    segments = SEG_7;
        4'd8:    segments = SEG_8;
        4'd9:    segments = SEG_9;
        default: segments = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_timer.sv
// Multi-digit BCD seconds timer with run/pause, clear, up/down, wrap or
// saturate, and a time-multiplexed seven-segment display driver.
module bcd_display_timer
  import bcd_display_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 16_000_000,
  parameter int MUX_DIV    = 16_000,
  parameter int BLANK_LZ   = 0
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic                        down,
  input  logic                        clear,
  input  logic                        wrap,
  output logic [BCD_W*NUM_DIGITS-1:0] count_bcd,
  output logic [6:0]                  segments,
  output logic [NUM_DIGITS-1:0]       digit_sel,
  output logic                        tick,
  output logic                        rollover,
  output logic                        at_limit
);

  localparam int CNT_W = BCD_W * NUM_DIGITS;
  localparam int PRE_W = cnt_width(TICK_DIV);
  localparam int MUX_W = cnt_width(MUX_DIV);
  localparam int IDX_W = cnt_width(NUM_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [MUX_W-1:0] MUX_LAST = MUX_W'(MUX_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [CNT_W-1:0]      count_q, count_d, count_stepped;
  logic                  tick_q, tick_d, rollover_q, rollover_d;
  logic                  step, carry;
  logic [MUX_W-1:0]      mdiv_q, mdiv_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [6:0]            seg_q, seg_d;
  logic [BCD_W-1:0]      mux_digit;
  logic                  mux_blank;

  // Prescaler: free-runs while run=1, clear forces it back to zero.
  always_comb begin
    step  = run && (pre_q == PRE_LAST) && !clear;
    pre_d = pre_q;
    if (clear)
      pre_d = '0;
    else if (run)
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
  end

  // Ripple carry/borrow through the digits; a carry out of the top digit means the count sits at its limit.
  always_comb begin
    count_stepped = count_q;
    carry         = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (down) begin
          if (count_q[BCD_W*i +: BCD_W] == 4'd0) begin
            count_stepped[BCD_W*i +: BCD_W] = 4'd9;
          end else begin
            count_stepped[BCD_W*i +: BCD_W] = count_q[BCD_W*i +: BCD_W] - 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (count_q[BCD_W*i +: BCD_W] == 4'd9) begin
            count_stepped[BCD_W*i +: BCD_W] = 4'd0;
          end else begin
            count_stepped[BCD_W*i +: BCD_W] = count_q[BCD_W*i +: BCD_W] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  // Count update: clear first, then a step either moves, wraps, or saturates.
  always_comb begin
    count_d    = count_q;
    tick_d     = 1'b0;
    rollover_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (step) begin
      tick_d = 1'b1;
      if (!carry) begin
        count_d = count_stepped;
      end else if (wrap) begin
        count_d    = count_stepped;
        rollover_d = 1'b1;
      end
    end
  end

  // Display mux: pick the next digit and decode it from the current count so digit_sel and segments move together.
  always_comb begin
    mdiv_d = mdiv_q + MUX_W'(1);
    idx_d  = idx_q;
    if (mdiv_q == MUX_LAST) begin
      mdiv_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    sel_d     = '0;
    mux_digit = '0;
    mux_blank = (BLANK_LZ != 0) && (idx_d != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        sel_d[i]  = 1'b1;
        mux_digit = count_q[BCD_W*i +: BCD_W];
      end
      if ((IDX_W'(i) >= idx_d) && (count_q[BCD_W*i +: BCD_W] != 4'd0))
        mux_blank = 1'b0;
    end
  end

  bcd_seg7_decoder u_dec (
    .bcd      (mux_digit),
    .blank    (mux_blank),
    .segments (seg_d)
  );

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q      <= '0;
      count_q    <= '0;
      tick_q     <= 1'b0;
      rollover_q <= 1'b0;
      mdiv_q     <= '0;
      idx_q      <= '0;
      sel_q      <= NUM_DIGITS'(1);
      seg_q      <= SEG_0;
    end else begin
      pre_q      <= pre_d;
      count_q    <= count_d;
      tick_q     <= tick_d;
      rollover_q <= rollover_d;
      mdiv_q     <= mdiv_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign count_bcd = count_q;
  assign tick      = tick_q;
  assign rollover  = rollover_q;
  assign digit_sel = sel_q;
  assign segments  = seg_q;
  assign at_limit  = carry;

endmodule

// File: doc/bcd_display_timer.md
Name: bcd_display_timer

Overview:
Parametrised multi-digit BCD seconds timer driving a time-multiplexed common-cathode seven-segment display. It is the next generation of the single-digit seconds counter, adding:
- N digits
- up/down counting
- run/pause and synchronous clear
- wrap or saturate at the limits
- leading-zero blanking
- tick and rollover status pulses

It sits between the board clock and the display pins in a tile top.

Parameters:
NUM_DIGITS, 4, number of BCD digits (1..8).
TICK_DIV, 16_000_000, clock cycles per count step (>=2); bench uses small values.
MUX_DIV, 16_000, clock cycles each digit is held on the display (>=1).
BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 is never blanked).

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
run  in  1  1 = prescaler advances; 0 = prescaler and count hold
down  in  1  1 = count down, 0 = count up; sampled on each tick
clear  in  1  synchronous clear of prescaler and count; overrides run
wrap  in  1  1 = wrap at limit, 0 = saturate at limit
count_bcd  out  4*NUM_DIGITS  current count; digit i in bits [4i+3:4i]
segments  out  7  active-high, bit0=a .. bit6=g, for the selected digit
digit_sel  out  NUM_DIGITS  one-hot, active-high digit enable
tick  out  1  one-cycle pulse coincident with each count step
rollover  out  1  one-cycle pulse coincident with a wrap event
at_limit  out  1  level: count is all-9s (up) or all-0s (down) per current down

Behaviour:
- Reset values (async):
  - prescaler = 0
  - count_bcd = 0
  - mux divider = 0; mux index = 0; digit_sel = 1 (digit 0)
  - segments = 7'h3F ('0')
  - tick = 0; rollover = 0
- Prescaler:
  - Width $clog2(TICK_DIV); counts 0..TICK_DIV-1 while run=1.
  - Step event = run && prescaler==TICK_DIV-1 && !clear; prescaler returns to 0 on the same edge.
  - Period is exactly TICK_DIV cycles.
- clear=1: prescaler <= 0 and count <= 0 on the next edge; tick/rollover <= 0. Clear wins over a simultaneous step event.
- Up step: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit. Digits are never outside 0..9.
- Down step: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
- Limit, up at all-9s:
  - wrap=1: count -> all-0s, rollover=1.
  - wrap=0: count holds, rollover=0.
  - tick pulses in both cases.
- Limit, down at all-0s: mirror of the up case; wrap=1 gives all-9s.
- tick and rollover are registered, high in the cycle in which count_bcd first shows the new value.
- at_limit is combinational from count_bcd and down.
- Changing down mid-interval takes effect at the next step; the prescaler is not disturbed.
- Mux:
  - Independent divider counts 0..MUX_DIV-1 regardless of run/clear.
  - On terminal value, mux index advances i -> (i+1) mod NUM_DIGITS.
  - digit_sel and segments are registered together, so they change on the same edge.
  - segments reflect count_bcd with one cycle of latency.
- Blanking: with BLANK_LZ=1, a digit i>0 whose value and all higher digits' values are 0 drives segments = 0 (digit_sel still asserted).
- Segment codes (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.

Decomposition:
- Shared package: segment code constants for 0..9 and blank, BCD digit width (4), and a localparam function for counter widths.
- One sub-module, bcd_seg7_decoder: 4-bit BCD plus blank in, 7-bit segments out; purely combinational. It is instantiated once, on the mux-selected digit.
- Prescaler, BCD chain and mux stay in the top module.

Test Plan:
Bench settings: NUM_DIGITS=2, TICK_DIV=4, MUX_DIV=2, BLANK_LZ=0 unless stated.
- Reset:
  - Stimulus: assert reset mid-count at 0x37.
  - Response: count_bcd=0x00, digit_sel=01 and segments=3F immediately (async); first tick exactly 4 cycles after release with run=1, count 0x01.
- Up carry and wrap:
  - Stimulus: run=1, up, wrap=1, from 0x09, then from 0x99.
  - Response: 0x09 steps to 0x10 (no rollover); 0x99 steps to 0x00 with tick=1 and rollover=1 for one cycle.
- Saturate:
  - Stimulus: wrap=0, down=1, count 0x00.
  - Response: count stays 0x00, tick pulses every 4 cycles, rollover=0, at_limit=1; switching to down=0 gives 0x01 at the next tick.
- Pause and clear priority:
  - Stimulus: run=0 for 10 cycles, then clear=1 in the step cycle.
  - Response: no count change while paused; prescaler resumes from its held value; with clear asserted, count=0x00, tick=0, and the next tick comes 4 cycles after clear deasserts.
- Mux and blanking:
  - Stimulus: count 0x05, BLANK_LZ=1.
  - Response: digit_sel alternates 01/10 every 2 cycles; segments=6D with digit 0 selected and 00 with digit 1 selected; with BLANK_LZ=0, digit 1 shows 3F.
